// File: rtl/pipe_wb_stage_if.sv
// MEM/WB stage bundle: MEM-stage results in, register-file write port and
// stage status out. The slave side is the write-back stage itself.
interface pipe_wb_stage_if #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int SELW = 3,
  parameter int CNTW = 32
);
  localparam int OFFW = $clog2(DW/8);

  logic            in_valid;
  logic            stall;
  logic            flush;
  logic [DW-1:0]   mem_aluc;
  logic [DW-1:0]   mem_dmem_out;
  logic [DW-1:0]   mem_pc4;
  logic            mem_rf_w_ena;
  logic [AW-1:0]   mem_rf_waddr;
  logic [SELW-1:0] mem_rf_mux_select;
  logic [2:0]      mem_load_mode;
  logic [OFFW-1:0] mem_byte_off;

  logic [DW-1:0]   rf_wdata;
  logic            rf_w_ena;
  logic [AW-1:0]   rf_waddr;
  logic            wb_valid;
  logic [CNTW-1:0] retired_count;

  modport slave (
    input  in_valid, stall, flush, mem_aluc, mem_dmem_out, mem_pc4,
           mem_rf_w_ena, mem_rf_waddr, mem_rf_mux_select, mem_load_mode,
           mem_byte_off,
    output rf_wdata, rf_w_ena, rf_waddr, wb_valid, retired_count
  );

  modport master (
    output in_valid, stall, flush, mem_aluc, mem_dmem_out, mem_pc4,
           mem_rf_w_ena, mem_rf_waddr, mem_rf_mux_select, mem_load_mode,
           mem_byte_off,
    input  rf_wdata, rf_w_ena, rf_waddr, wb_valid, retired_count
  );
endinterface

// File: rtl/pipe_wb_stage.sv
// MEM/WB pipeline register fused with the write-back result mux, sub-word
// load extension, r0 write suppression and a retired-instruction counter.
module pipe_wb_stage #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int SELW = 3,
  parameter int CNTW = 32
) (
  input  logic         clk,
  input  logic         rst,
  pipe_wb_stage_if.slave wb
);
  localparam int OFFW = $clog2(DW/8);

  logic [DW-1:0]   byte_shift;
  logic [DW-1:0]   half_shift;
  logic [DW-1:0]   load_ext;
  logic [DW-1:0]   mux_out;

  logic [DW-1:0]   rf_wdata_d, rf_wdata_q;
  logic            rf_w_ena_d, rf_w_ena_q;
  logic [AW-1:0]   rf_waddr_d, rf_waddr_q;
  logic            wb_valid_d, wb_valid_q;
  logic [CNTW-1:0] retired_count_d, retired_count_q;

  // Lane selection by shifting the addressed byte/halfword down to bit 0.
  always_comb begin
    byte_shift = wb.mem_dmem_out >> {wb.mem_byte_off, 3'b000};
    half_shift = wb.mem_dmem_out >> {wb.mem_byte_off[OFFW-1:1], 4'b0000};
    case (wb.mem_load_mode)
      3'd1:    load_ext = {{(DW-8){byte_shift[7]}}, byte_shift[7:0]};
      3'd2:    load_ext = {{(DW-8){1'b0}}, byte_shift[7:0]};
      3'd3:    load_ext = {{(DW-16){half_shift[15]}}, half_shift[15:0]};
      3'd4:    load_ext = {{(DW-16){1'b0}}, half_shift[15:0]};
      default: load_ext = wb.mem_dmem_out;
    endcase
  end

  always_comb begin
    case (wb.mem_rf_mux_select)
      SELW'(1): mux_out = wb.mem_pc4;
      SELW'(4): mux_out = load_ext;
      SELW'(5): mux_out = wb.mem_aluc;
      default:  mux_out = '0;
    endcase
  end

  // Priority below reset: flush > stall > capture.
  always_comb begin
    rf_wdata_d      = rf_wdata_q;
    rf_w_ena_d      = rf_w_ena_q;
    rf_waddr_d      = rf_waddr_q;
    wb_valid_d      = wb_valid_q;
    retired_count_d = retired_count_q;
    if (wb.flush) begin
      rf_wdata_d = '0;
      rf_w_ena_d = 1'b0;
      rf_waddr_d = '0;
      wb_valid_d = 1'b0;
    end else if (!wb.stall) begin
      rf_wdata_d = mux_out;
      rf_w_ena_d = wb.in_valid & wb.mem_rf_w_ena & (wb.mem_rf_waddr != '0);
      rf_waddr_d = wb.mem_rf_waddr;
      wb_valid_d = wb.in_valid;
      if (wb.in_valid) begin
        retired_count_d = retired_count_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wdata_q      <= '0;
      rf_w_ena_q      <= 1'b0;
      rf_waddr_q      <= '0;
      wb_valid_q      <= 1'b0;
      retired_count_q <= '0;
    end else begin
      rf_wdata_q      <= rf_wdata_d;
      rf_w_ena_q      <= rf_w_ena_d;
      rf_waddr_q      <= rf_waddr_d;
      wb_valid_q      <= wb_valid_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign wb.rf_wdata      = rf_wdata_q;
  assign wb.rf_w_ena      = rf_w_ena_q;
  assign wb.rf_waddr      = rf_waddr_q;
  assign wb.wb_valid      = wb_valid_q;
  assign wb.retired_count = retired_count_q;
endmodule

// File: tb/tb_pipe_wb_stage.sv
// Bench for pipe_wb_stage: directed vector table, stall/flush/reset/wrap
// sequences and randomized traffic against a lane-array reference model.
module tb_pipe_wb_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_wb_stage_if ifa ();
  pipe_wb_stage_if #(.CNTW(4)) ifc ();

  pipe_wb_stage dut_a (.clk(clk), .rst(rst), .wb(ifa));
  pipe_wb_stage #(.CNTW(4)) dut_c (.clk(clk), .rst(rst), .wb(ifc));

  assign ifc.in_valid          = ifa.in_valid;
  assign ifc.stall             = ifa.stall;
  assign ifc.flush             = ifa.flush;
  assign ifc.mem_aluc          = ifa.mem_aluc;
  assign ifc.mem_dmem_out      = ifa.mem_dmem_out;
  assign ifc.mem_pc4           = ifa.mem_pc4;
  assign ifc.mem_rf_w_ena      = ifa.mem_rf_w_ena;
  assign ifc.mem_rf_waddr      = ifa.mem_rf_waddr;
  assign ifc.mem_rf_mux_select = ifa.mem_rf_mux_select;
  assign ifc.mem_load_mode     = ifa.mem_load_mode;
  assign ifc.mem_byte_off      = ifa.mem_byte_off;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_wdata;
  logic        m_wena;
  logic [4:0]  m_waddr;
  logic        m_valid;
  int unsigned m_count;

  typedef struct {
    logic        valid;
    logic        wena;
    logic [4:0]  waddr;
    logic [2:0]  sel;
    logic [2:0]  mode;
    logic [1:0]  off;
    logic [31:0] aluc;
    logic [31:0] dmem;
    logic [31:0] pc4;
    logic [31:0] exp_wdata;
    logic        exp_wena;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result: pick lanes out of a byte array and extend arithmetically.
  function automatic logic [31:0] ref_mux(input logic [2:0] sel, input logic [2:0] mode,
                                          input logic [1:0] off, input logic [31:0] aluc,
                                          input logic [31:0] dmem, input logic [31:0] pc4);
    logic [7:0]         lanes[4];
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    int                 h;
    int                 v;
    for (int i = 0; i < 4; i++) lanes[i] = dmem[8*i +: 8];
    h  = (int'(off) / 2) * 2;
    sb = lanes[off];
    sh = {lanes[h+1], lanes[h]};
    if (sel == 3'd1) return pc4;
    if (sel == 3'd5) return aluc;
    if (sel != 3'd4) return 32'h0;
    case (mode)
      3'd1: begin v = sb; return v; end
      3'd2: return 32'(int'(lanes[off]));
      3'd3: begin v = sh; return v; end
      3'd4: return 32'(int'(unsigned'(sh)));
      default: return dmem;
    endcase
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_wdata = 0; m_wena = 0; m_waddr = 0; m_valid = 0; m_count = 0;
    end else if (ifa.flush) begin
      m_wdata = 0; m_wena = 0; m_waddr = 0; m_valid = 0;
    end else if (!ifa.stall) begin
      m_valid = ifa.in_valid;
      m_waddr = ifa.mem_rf_waddr;
      m_wena  = ifa.in_valid && ifa.mem_rf_w_ena && (ifa.mem_rf_waddr != 0);
      m_wdata = ref_mux(ifa.mem_rf_mux_select, ifa.mem_load_mode, ifa.mem_byte_off,
                        ifa.mem_aluc, ifa.mem_dmem_out, ifa.mem_pc4);
      if (ifa.in_valid) m_count++;
    end
  endtask

  task automatic check_all();
    chk("rf_wdata", ifa.rf_wdata, m_wdata);
    chk("rf_w_ena", 32'(ifa.rf_w_ena), 32'(m_wena));
    chk("rf_waddr", 32'(ifa.rf_waddr), 32'(m_waddr));
    chk("wb_valid", 32'(ifa.wb_valid), 32'(m_valid));
    chk("retired_count", ifa.retired_count, m_count);
    chk("c_rf_wdata", ifc.rf_wdata, m_wdata);
    chk("c_retired_count", 32'(ifc.retired_count), m_count % 16);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_inputs();
    ifa.in_valid          = 1'($urandom);
    ifa.mem_aluc          = $urandom;
    ifa.mem_dmem_out      = $urandom;
    ifa.mem_pc4           = $urandom;
    ifa.mem_rf_w_ena      = 1'($urandom);
    ifa.mem_rf_waddr      = 5'($urandom);
    ifa.mem_rf_mux_select = 3'($urandom);
    ifa.mem_load_mode     = 3'($urandom);
    ifa.mem_byte_off      = 2'($urandom);
  endtask

  task automatic apply_vec(input vec_t v);
    ifa.in_valid          = v.valid;
    ifa.mem_rf_w_ena      = v.wena;
    ifa.mem_rf_waddr      = v.waddr;
    ifa.mem_rf_mux_select = v.sel;
    ifa.mem_load_mode     = v.mode;
    ifa.mem_byte_off      = v.off;
    ifa.mem_aluc          = v.aluc;
    ifa.mem_dmem_out      = v.dmem;
    ifa.mem_pc4           = v.pc4;
  endtask

  function automatic vec_t mk(input logic valid, input logic wena, input logic [4:0] waddr,
                              input logic [2:0] sel, input logic [2:0] mode, input logic [1:0] off,
                              input logic [31:0] aluc, input logic [31:0] dmem, input logic [31:0] pc4,
                              input logic [31:0] exp_wdata, input logic exp_wena);
    vec_t v;
    v.valid = valid; v.wena = wena; v.waddr = waddr; v.sel = sel; v.mode = mode; v.off = off;
    v.aluc = aluc; v.dmem = dmem; v.pc4 = pc4; v.exp_wdata = exp_wdata; v.exp_wena = exp_wena;
    return v;
  endfunction

  initial begin
    logic [31:0] d;
    int unsigned cnt_hold;
    d = 32'h80FF7F01;
    vecs.push_back(mk(1, 1, 8,  5, 0, 0, 32'h12345678, d, 32'h0, 32'h12345678, 1));
    vecs.push_back(mk(1, 1, 9,  1, 0, 0, 32'h0, d, 32'h00400010, 32'h00400010, 1));
    vecs.push_back(mk(1, 1, 10, 4, 1, 3, 32'h0, d, 32'h0, 32'hFFFFFF80, 1));
    vecs.push_back(mk(1, 1, 11, 4, 2, 1, 32'h0, d, 32'h0, 32'h0000007F, 1));
    vecs.push_back(mk(1, 1, 12, 4, 3, 2, 32'h0, d, 32'h0, 32'hFFFF80FF, 1));
    vecs.push_back(mk(1, 1, 13, 4, 4, 0, 32'h0, d, 32'h0, 32'h00007F01, 1));
    vecs.push_back(mk(1, 1, 14, 4, 6, 1, 32'h0, d, 32'h0, 32'h80FF7F01, 1));
    vecs.push_back(mk(1, 1, 15, 4, 0, 2, 32'h0, d, 32'h0, 32'h80FF7F01, 1));
    vecs.push_back(mk(1, 1, 16, 4, 3, 1, 32'h0, d, 32'h0, 32'h00007F01, 1));
    vecs.push_back(mk(1, 1, 17, 2, 0, 0, 32'hDEAD0000, d, 32'h4, 32'h0, 1));
    vecs.push_back(mk(1, 1, 18, 7, 0, 0, 32'hDEAD0000, d, 32'h4, 32'h0, 1));
    vecs.push_back(mk(1, 1, 0,  5, 0, 0, 32'hCAFE0001, d, 32'h0, 32'hCAFE0001, 0));
    vecs.push_back(mk(0, 1, 19, 5, 0, 0, 32'h0BAD0002, d, 32'h0, 32'h0BAD0002, 0));
    vecs.push_back(mk(1, 0, 20, 5, 0, 0, 32'h00000055, d, 32'h0, 32'h00000055, 0));

    // Reset with random inputs for two cycles.
    rst = 1'b1; ifa.stall = 1'b0; ifa.flush = 1'b0;
    m_wdata = 0; m_wena = 0; m_waddr = 0; m_valid = 0; m_count = 0;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      ifa.stall = 1'($urandom); ifa.flush = 1'($urandom);
      cyc();
    end
    chk("reset_wdata", ifa.rf_wdata, 32'h0);
    chk("reset_wena", 32'(ifa.rf_w_ena), 32'h0);
    chk("reset_count", ifa.retired_count, 32'h0);
    rst = 1'b0; ifa.stall = 1'b0; ifa.flush = 1'b0;
    apply_vec(vecs[0]);
    cyc();
    chk("first_count", ifa.retired_count, 32'd1);

    // Directed vector table.
    foreach (vecs[i]) begin
      apply_vec(vecs[i]);
      cyc();
      chk($sformatf("vec%0d_wdata", i), ifa.rf_wdata, vecs[i].exp_wdata);
      chk($sformatf("vec%0d_wena", i), 32'(ifa.rf_w_ena), 32'(vecs[i].exp_wena));
      chk($sformatf("vec%0d_valid", i), 32'(ifa.wb_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_waddr", i), 32'(ifa.rf_waddr), 32'(vecs[i].waddr));
    end

    // Stall: instruction A must hold for three cycles, counter included.
    apply_vec(mk(1, 1, 3, 5, 0, 0, 32'hA5A50001, d, 32'h0, 32'hA5A50001, 1));
    cyc();
    cnt_hold = m_count;
    ifa.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      ifa.in_valid = 1'b1;
      cyc();
      chk("stall_wdata", ifa.rf_wdata, 32'hA5A50001);
      chk("stall_waddr", 32'(ifa.rf_waddr), 32'd3);
      chk("stall_wena", 32'(ifa.rf_w_ena), 32'd1);
      chk("stall_count", ifa.retired_count, cnt_hold);
    end

    // Flush wins over stall.
    ifa.flush = 1'b1;
    cyc();
    chk("flush_valid", 32'(ifa.wb_valid), 32'd0);
    chk("flush_wena", 32'(ifa.rf_w_ena), 32'd0);
    chk("flush_count", ifa.retired_count, cnt_hold);
    ifa.flush = 1'b0; ifa.stall = 1'b0;

    // Counter wrap on the 4-bit instance.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      rand_inputs();
      ifa.in_valid = 1'b1;
      cyc();
    end
    chk("wrap_count4", 32'(ifc.retired_count), 32'd1);
    chk("wrap_count32", ifa.retired_count, 32'd17);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      rst       = ($urandom_range(0, 49) == 0);
      ifa.flush = ($urandom_range(0, 9) == 0);
      ifa.stall = ($urandom_range(0, 5) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
